// File: rtl/puck_pkg.sv
// Shared definitions for the puck controller and the score/display blocks:
// FSM encoding, position/velocity widths, default field geometry and velocity helpers.
package puck_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COLL   = 3'd1,
    MOVE   = 3'd2,
    WALL   = 3'd3,
    UPDATE = 3'd4,
    GOAL   = 3'd5
  } puck_state_e;

  localparam int VEL_W = 5;
  localparam int POS_W = 13;

  typedef logic signed [VEL_W-1:0] vel_t;
  typedef logic signed [POS_W-1:0] pos_t;

  localparam int FIELD_W_DEF     = 1024;
  localparam int FIELD_H_DEF     = 768;
  localparam int PUCK_R_DEF      = 12;
  localparam int MAX_SPEED_DEF   = 8;
  localparam int GOAL_Y_MIN_DEF  = 284;
  localparam int GOAL_Y_MAX_DEF  = 484;
  localparam int HOLD_FRAMES_DEF = 60;

  function automatic vel_t sat_vel(input pos_t v, input pos_t lim);
    pos_t neg_lim;
    vel_t r;
    neg_lim = -lim;
    if (v > lim) begin
      r = lim[VEL_W-1:0];
    end else if (v < neg_lim) begin
      r = neg_lim[VEL_W-1:0];
    end else begin
      r = v[VEL_W-1:0];
    end
    return r;
  endfunction

  function automatic vel_t toward_zero(input vel_t v);
    vel_t r;
    if (v > 5'sd0) begin
      r = v - 5'sd1;
    end else if (v < 5'sd0) begin
      r = v + 5'sd1;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/puck_if.sv
// Player-position / frame-sync inputs and puck-position / goal outputs of the puck controller.
interface puck_if;
  logic        vsync_in;
  logic [11:0] player_x;
  logic [11:0] player_y;
  logic [7:0]  radius_player;
  logic [11:0] puck_x_out;
  logic [11:0] puck_y_out;
  logic        goal_left;
  logic        goal_right;

  modport master (
    output vsync_in, player_x, player_y, radius_player,
    input  puck_x_out, puck_y_out, goal_left, goal_right
  );

  modport slave (
    input  vsync_in, player_x, player_y, radius_player,
    output puck_x_out, puck_y_out, goal_left, goal_right
  );
endinterface

// File: rtl/puck_collide.sv
// Puck/player distance compare and the resulting saturated velocity (pure combinational).
module puck_collide
  import puck_pkg::*;
#(
  parameter int PUCK_R    = PUCK_R_DEF,
  parameter int MAX_SPEED = MAX_SPEED_DEF
) (
  input  pos_t        pos_x,
  input  pos_t        pos_y,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  input  logic [7:0]  radius_player,
  output logic        hit,
  output vel_t        vx_hit,
  output vel_t        vy_hit
);

  localparam pos_t LIM = pos_t'(MAX_SPEED);

  pos_t        dx, dy, ndx, ndy;
  logic [11:0] adx, ady;
  logic [8:0]  rsum;
  logic [25:0] dx2, dy2, rr2;

  // Squared distance against squared radius sum; squares of magnitudes avoid signed multiply
  always_comb begin
    dx     = pos_x - $signed({1'b0, player_x});
    dy     = pos_y - $signed({1'b0, player_y});
    ndx    = -dx;
    ndy    = -dy;
    adx    = dx[POS_W-1] ? ndx[11:0] : dx[11:0];
    ady    = dy[POS_W-1] ? ndy[11:0] : dy[11:0];
    dx2    = {14'd0, adx} * {14'd0, adx};
    dy2    = {14'd0, ady} * {14'd0, ady};
    rsum   = 9'(PUCK_R) + {1'b0, radius_player};
    rr2    = {17'd0, rsum} * {17'd0, rsum};
    hit    = (dx2 + dy2) <= rr2;
    vx_hit = sat_vel(dx >>> 2'd2, LIM);
    vy_hit = sat_vel(dy >>> 2'd2, LIM);
  end

endmodule

// File: rtl/puck_ctl.sv
// Per-frame puck physics: collide, move, wall/goal resolve, publish; goal hold at centre.
// Optional build macro PUCK_FRICTION_EN adds velocity decay every 8th frame.
module puck_ctl
  import puck_pkg::*;
#(
  parameter int FIELD_W     = FIELD_W_DEF,
  parameter int FIELD_H     = FIELD_H_DEF,
  parameter int PUCK_R      = PUCK_R_DEF,
  parameter int MAX_SPEED   = MAX_SPEED_DEF,
  parameter int GOAL_Y_MIN  = GOAL_Y_MIN_DEF,
  parameter int GOAL_Y_MAX  = GOAL_Y_MAX_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF
) (
  input logic   clk_in,
  input logic   rst,
  puck_if.slave bus
);

  localparam pos_t R_S    = pos_t'(PUCK_R);
  localparam pos_t X_MAX  = pos_t'(FIELD_W - 1 - PUCK_R);
  localparam pos_t Y_MAX  = pos_t'(FIELD_H - 1 - PUCK_R);
  localparam pos_t GY_MIN = pos_t'(GOAL_Y_MIN);
  localparam pos_t GY_MAX = pos_t'(GOAL_Y_MAX);
  localparam pos_t CX     = pos_t'(FIELD_W / 2);
  localparam pos_t CY     = pos_t'(FIELD_H / 2);
  localparam int   HOLD_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

  puck_state_e       state_q, state_d;
  logic              vsync_q, vsync_d, tick;
  pos_t              x_q, x_d, y_q, y_d;
  vel_t              vx_q, vx_d, vy_q, vy_d;
  logic [11:0]       xo_q, xo_d, yo_q, yo_d;
  logic              gl_q, gl_d, gr_q, gr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
`ifdef PUCK_FRICTION_EN
  logic [2:0]        fric_q, fric_d;
`endif

  logic hit;
  vel_t vx_hit, vy_hit;
  pos_t y_w;
  vel_t vy_w;
  logic in_mouth, goal_l, goal_r;

  puck_collide #(.PUCK_R(PUCK_R), .MAX_SPEED(MAX_SPEED)) u_collide (
    .pos_x(x_q), .pos_y(y_q),
    .player_x(bus.player_x), .player_y(bus.player_y), .radius_player(bus.radius_player),
    .hit(hit), .vx_hit(vx_hit), .vy_hit(vy_hit)
  );

  assign tick = bus.vsync_in & ~vsync_q;

  // y reflection is resolved first so the goal-mouth test sees the clamped y
  always_comb begin
    y_w  = y_q;
    vy_w = vy_q;
    if (y_q < R_S) begin
      y_w  = R_S;
      vy_w = -vy_q;
    end else if (y_q > Y_MAX) begin
      y_w  = Y_MAX;
      vy_w = -vy_q;
    end else begin
      y_w  = y_q;
      vy_w = vy_q;
    end
    in_mouth = (y_w >= GY_MIN) && (y_w <= GY_MAX);
    goal_l   = (x_q < R_S) && in_mouth;
    goal_r   = (x_q > X_MAX) && in_mouth;
  end

  // Next-state and datapath updates for one frame step
  always_comb begin
    state_d = state_q;
    vsync_d = bus.vsync_in;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    gl_d    = 1'b0;
    gr_d    = 1'b0;
    hold_d  = hold_q;
`ifdef PUCK_FRICTION_EN
    fric_d  = fric_q;
`endif
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = COLL;
        end else begin
          state_d = IDLE;
        end
      end
      COLL: begin
        if (hit) begin
          vx_d = vx_hit;
          vy_d = vy_hit;
        end else begin
          vx_d = vx_q;
          vy_d = vy_q;
        end
        state_d = MOVE;
      end
      MOVE: begin
        x_d     = x_q + {{(POS_W-VEL_W){vx_q[VEL_W-1]}}, vx_q};
        y_d     = y_q + {{(POS_W-VEL_W){vy_q[VEL_W-1]}}, vy_q};
        state_d = WALL;
      end
      WALL: begin
        if (goal_l || goal_r) begin
          x_d     = CX;
          y_d     = CY;
          vx_d    = 5'sd0;
          vy_d    = 5'sd0;
          xo_d    = CX[11:0];
          yo_d    = CY[11:0];
          gl_d    = goal_l;
          gr_d    = goal_r;
          hold_d  = '0;
`ifdef PUCK_FRICTION_EN
          fric_d  = 3'd0;
`endif
          state_d = GOAL;
        end else begin
          if (x_q < R_S) begin
            x_d  = R_S;
            vx_d = -vx_q;
          end else if (x_q > X_MAX) begin
            x_d  = X_MAX;
            vx_d = -vx_q;
          end else begin
            x_d  = x_q;
            vx_d = vx_q;
          end
          y_d     = y_w;
          vy_d    = vy_w;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        xo_d = x_q[11:0];
        yo_d = y_q[11:0];
`ifdef PUCK_FRICTION_EN
        fric_d = fric_q + 3'd1;
        if (fric_q == 3'd7) begin
          vx_d = toward_zero(vx_q);
          vy_d = toward_zero(vy_q);
        end else begin
          vx_d = vx_q;
          vy_d = vy_q;
        end
`endif
        state_d = IDLE;
      end
      GOAL: begin
        if (tick) begin
          if (hold_q == HOLD_LAST) begin
            hold_d  = '0;
            state_d = IDLE;
          end else begin
            hold_d  = hold_q + HOLD_W'(1);
            state_d = GOAL;
          end
        end else begin
          state_d = GOAL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset discards any partial frame
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      vsync_q <= 1'b0;
      x_q     <= CX;
      y_q     <= CY;
      vx_q    <= 5'sd0;
      vy_q    <= 5'sd0;
      xo_q    <= CX[11:0];
      yo_q    <= CY[11:0];
      gl_q    <= 1'b0;
      gr_q    <= 1'b0;
      hold_q  <= '0;
`ifdef PUCK_FRICTION_EN
      fric_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      vsync_q <= vsync_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      gl_q    <= gl_d;
      gr_q    <= gr_d;
      hold_q  <= hold_d;
`ifdef PUCK_FRICTION_EN
      fric_q  <= fric_d;
`endif
    end
  end

  assign bus.puck_x_out = xo_q;
  assign bus.puck_y_out = yo_q;
  assign bus.goal_left  = gl_q;
  assign bus.goal_right = gr_q;

endmodule

// File: tb/tb_puck_ctl.sv
// Directed bench for puck_ctl: a table of frame sequences with hand-computed end positions
// and goal pulse counts, plus hand sequences for reset-in-MOVE, latency and ignored ticks.
module tb_puck_ctl;

  logic clk_in;
  logic rst;
  puck_if bus ();

  puck_ctl dut (.clk_in(clk_in), .rst(rst), .bus(bus));

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    bit    do_rst;
    int    n;
    int    px, py, pr;
    int    ex, ey, egl, egr;
    string name;
  } vec_t;

  localparam int NV = 26;
  localparam int FX = 4095, FY = 4095, FR = 0;
`ifdef PUCK_FRICTION_EN
  localparam int X40 = 632, X41 = 632;
`else
  localparam int X40 = 712, X41 = 717;
`endif

  vec_t tbl[NV];
  int total = 0;
  int bad   = 0;
  int gl_seen = 0, gr_seen = 0;
  int gl0, gr0;

  always @(negedge clk_in) begin
    if (bus.goal_left)  gl_seen++;
    if (bus.goal_right) gr_seen++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst = 1'b1;
    bus.vsync_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic frame(input int px, input int py, input int pr);
    @(negedge clk_in);
    bus.player_x      = 12'(px);
    bus.player_y      = 12'(py);
    bus.radius_player = 8'(pr);
    bus.vsync_in      = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    @(negedge clk_in);
    bus.vsync_in = 1'b0;
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    rst = 1'b1;
    bus.vsync_in      = 1'b0;
    bus.player_x      = 12'(FX);
    bus.player_y      = 12'(FY);
    bus.radius_player = 8'(FR);
    repeat (3) @(posedge clk_in);
    #1;
    check("reset.x",  int'(bus.puck_x_out), 512);
    check("reset.y",  int'(bus.puck_y_out), 384);
    check("reset.gl", int'(bus.goal_left),  0);
    check("reset.gr", int'(bus.goal_right), 0);
    @(negedge clk_in);
    rst = 1'b0;

    tbl[0]  = '{1'b1,  3, FX,  FY,  FR, 512, 384, 0, 0, "far3"};
    tbl[1]  = '{1'b0,  1, 500, 384, 20, 515, 384, 0, 0, "hit_vx3"};
    tbl[2]  = '{1'b0,  1, FX,  FY,  FR, 518, 384, 0, 0, "coast"};
    tbl[3]  = '{1'b0,  1, 518, 384, 0,  518, 384, 0, 0, "stop"};
    tbl[4]  = '{1'b0,  2, FX,  FY,  FR, 518, 384, 0, 0, "still"};
    tbl[5]  = '{1'b1,  1, 512, 424, 60, 512, 376, 0, 0, "kick_up"};
    tbl[6]  = '{1'b0, 45, FX,  FY,  FR, 512, 16,  0, 0, "rise"};
    tbl[7]  = '{1'b0,  1, FX,  FY,  FR, 512, 12,  0, 0, "top_clamp"};
    tbl[8]  = '{1'b0,  1, FX,  FY,  FR, 512, 20,  0, 0, "top_bounce"};
    tbl[9]  = '{1'b1,  1, 500, 400, 20, 515, 380, 0, 0, "kick_diag"};
    tbl[10] = '{1'b0, 70, FX,  FY,  FR, 725, 100, 0, 0, "diag_run"};
    tbl[11] = '{1'b0,  1, 685, 100, 60, 733, 100, 0, 0, "kick_right"};
    tbl[12] = '{1'b0, 34, FX,  FY,  FR, 1005, 100, 0, 0, "right_run"};
    tbl[13] = '{1'b0,  1, FX,  FY,  FR, 1011, 100, 0, 0, "rwall_clamp"};
    tbl[14] = '{1'b0,  1, FX,  FY,  FR, 1003, 100, 0, 0, "rwall_back"};
    tbl[15] = '{1'b1,  1, 552, 384, 60, 504, 384, 0, 0, "kick_left"};
    tbl[16] = '{1'b0, 61, FX,  FY,  FR, 16,  384, 0, 0, "left_run"};
    tbl[17] = '{1'b0,  1, FX,  FY,  FR, 512, 384, 1, 0, "goal_left"};
    tbl[18] = '{1'b0, 60, 500, 384, 20, 512, 384, 0, 0, "hold60"};
    tbl[19] = '{1'b0,  1, 500, 384, 20, 515, 384, 0, 0, "after_hold"};
    tbl[20] = '{1'b1,  1, 472, 384, 60, 520, 384, 0, 0, "kick_r"};
    tbl[21] = '{1'b0, 61, FX,  FY,  FR, 1008, 384, 0, 0, "r_run"};
    tbl[22] = '{1'b0,  1, FX,  FY,  FR, 512, 384, 0, 1, "goal_right"};
    tbl[23] = '{1'b1,  1, 492, 384, 20, 517, 384, 0, 0, "kick_vx5"};
    tbl[24] = '{1'b0, 39, FX,  FY,  FR, X40, 384, 0, 0, "vx5_40"};
    tbl[25] = '{1'b0,  1, FX,  FY,  FR, X41, 384, 0, 0, "vx5_41"};

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].do_rst) do_reset();
      gl0 = gl_seen;
      gr0 = gr_seen;
      for (int k = 0; k < tbl[i].n; k++) frame(tbl[i].px, tbl[i].py, tbl[i].pr);
      check({tbl[i].name, ".x"},  int'(bus.puck_x_out), tbl[i].ex);
      check({tbl[i].name, ".y"},  int'(bus.puck_y_out), tbl[i].ey);
      check({tbl[i].name, ".gl"}, gl_seen - gl0, tbl[i].egl);
      check({tbl[i].name, ".gr"}, gr_seen - gr0, tbl[i].egr);
    end

    // Reset asserted while the FSM sits in MOVE, then a clean frame with latency check
    do_reset();
    frame(500, 384, 20);
    check("rstmove.pre_x", int'(bus.puck_x_out), 515);
    @(negedge clk_in);
    bus.vsync_in = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    bus.vsync_in = 1'b0;
    @(posedge clk_in);
    #1;
    check("rstmove.x",  int'(bus.puck_x_out), 512);
    check("rstmove.y",  int'(bus.puck_y_out), 384);
    check("rstmove.gl", int'(bus.goal_left),  0);
    check("rstmove.gr", int'(bus.goal_right), 0);
    @(negedge clk_in);
    rst = 1'b0;
    repeat (2) @(negedge clk_in);
    bus.vsync_in = 1'b1;
    @(posedge clk_in);
    repeat (3) @(posedge clk_in);
    #1;
    check("latency.n3_x", int'(bus.puck_x_out), 512);
    @(posedge clk_in);
    #1;
    check("latency.n4_x", int'(bus.puck_x_out), 515);
    @(negedge clk_in);
    bus.vsync_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Second vsync edge while busy must be dropped, not queued
    do_reset();
    @(negedge clk_in);
    bus.player_x      = 12'd500;
    bus.player_y      = 12'd384;
    bus.radius_player = 8'd20;
    bus.vsync_in      = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    bus.vsync_in = 1'b0;
    @(negedge clk_in);
    bus.vsync_in = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check("ignored.x", int'(bus.puck_x_out), 515);
    repeat (10) @(posedge clk_in);
    #1;
    check("ignored.noqueue_x", int'(bus.puck_x_out), 515);
    @(negedge clk_in);
    bus.vsync_in = 1'b0;
    repeat (3) @(negedge clk_in);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puck_ctl.md
PUCK_CTL -- requirements
Module: puck_ctl

Interface
REQ-001 SHALL have parameters: FIELD_W 1024, playfield width in px; FIELD_H 768, playfield height in px; PUCK_R 12, puck radius in px; MAX_SPEED 8, max abs velocity per axis in px/frame; GOAL_Y_MIN 284, lower bound of goal mouth y; GOAL_Y_MAX 484, upper bound of goal mouth y; HOLD_FRAMES 60, frames the puck is held at centre after a goal.
REQ-002 SHALL have ports: clk_in in 1, pixel clock; rst in 1, synchronous active-high reset; vsync_in in 1, frame sync from timing chain; player_x in 12, player centre x; player_y in 12, player centre y; radius_player in 8, player radius; puck_x_out out 12, puck centre x; puck_y_out out 12, puck centre y; goal_left out 1, one-cycle pulse for a goal scored into the left mouth; goal_right out 1, one-cycle pulse for a goal scored into the right mouth.
REQ-003 SHALL sample player_x, player_y and radius_player directly from the player draw_circle stage (xpos_out, ypos_out, radius_player); puck_x_out/puck_y_out SHALL drive xpos_in/ypos_in of the puck draw_circle stage.

Function
REQ-004 SHALL register vsync_in once per cycle; frame tick = registered value 0 and current vsync_in 1, asserted for exactly one cycle.
REQ-005 SHALL implement FSM states IDLE, COLL, MOVE, WALL, UPDATE, GOAL; IDLE->COLL on tick; COLL->MOVE->WALL unconditionally; WALL->GOAL on goal, else WALL->UPDATE; UPDATE->IDLE.
REQ-006 SHALL ignore ticks arriving in any state other than IDLE or GOAL; ignored ticks are not queued.
REQ-007 COLL: dx = puck_x - player_x, dy = puck_y - player_y as 13-bit signed; collision when dx*dx + dy*dy <= (PUCK_R + radius_player)^2, using unsigned 26-bit arithmetic with no truncation.
REQ-008 On collision, vx SHALL become dx arithmetically shifted right by 2 and vy SHALL become dy arithmetically shifted right by 2, each saturated to +/-MAX_SPEED; a zero component SHALL stay zero; velocity SHALL be unchanged when there is no collision.
REQ-009 MOVE: the internal 13-bit signed positions SHALL add vx and vy.
REQ-010 WALL, y-axis: if y < PUCK_R then y = PUCK_R and vy = -vy; if y > FIELD_H-1-PUCK_R then y = FIELD_H-1-PUCK_R and vy = -vy.
REQ-011 WALL, x-axis: if x < PUCK_R and GOAL_Y_MIN <= y <= GOAL_Y_MAX, this is a left goal; if x > FIELD_W-1-PUCK_R with y in the same window, this is a right goal; otherwise x SHALL be clamped and vx negated, using the same rule as y.
REQ-012 A y-wall reflection SHALL be applied before the x goal check within the same WALL cycle; a corner hit SHALL negate both velocity components.
REQ-013 UPDATE SHALL copy the internal positions to puck_x_out/puck_y_out; outputs change only in UPDATE or on goal/reset, so there is exactly one position change per frame.
REQ-014 Latency: the outputs SHALL show the new position 4 clk_in edges after the tick cycle (tick at edge N leads to new outputs after edge N+4).
REQ-015 On goal entry: pulse goal_left or goal_right for one cycle, set the position and outputs to (FIELD_W/2, FIELD_H/2), and set vx = vy = 0.
REQ-016 GOAL SHALL count ticks; after HOLD_FRAMES ticks it SHALL go to IDLE; collisions SHALL not be evaluated during GOAL.
REQ-017 With zero velocity and no collision, the outputs SHALL be rewritten with unchanged values each frame.

Reset
REQ-018 While rst=1 at a clk_in edge: state IDLE, position and outputs (FIELD_W/2, FIELD_H/2), vx = vy = 0, goal_left = goal_right = 0, hold counter 0, and the vsync register 0.
REQ-019 Reset SHALL override any state, including a partially completed frame update or GOAL hold; the partial update SHALL be discarded.

Configuration
REQ-020 Macro PUCK_FRICTION_EN: when defined, a 3-bit frame counter advances in UPDATE, and every 8th UPDATE moves each nonzero velocity component 1 toward zero; the counter resets on rst and on goal.
REQ-021 Without PUCK_FRICTION_EN, velocity SHALL change only via collision, reflection, goal or reset, and the frame counter logic SHALL not exist.

Structure
REQ-022 Shared package puck_pkg SHALL hold the FSM state encoding, the velocity width (5-bit signed) and the field default constants, for reuse by the score/display blocks.
REQ-023 Sub-module puck_collide SHALL contain the REQ-007/008 combinational distance compare and velocity saturation; the FSM, position registers and goal logic SHALL stay in puck_ctl.

Verification
REQ-024 Reset, then 3 ticks with the player far away: the outputs stay (512,384) and goal pulses stay 0.
REQ-025 Puck at (512,384), player at (500,384), radius 20: one tick gives vx=+3, vy=0, and the outputs read (515,384) 4 cycles after the tick.
REQ-026 Puck at (1005,100), vx=+8: after the tick x is clamped to 1011 and vx=-8; no goal fires because y is outside the goal window.
REQ-027 Puck at (8,384), vx=-8: goal_left pulses for one cycle, the outputs become (512,384), and the next 60 ticks produce no movement even with the player overlapping.
REQ-028 rst asserted in the MOVE state: the next cycle shows the REQ-018 values, and a following tick produces the normal 4-cycle update.
REQ-029 With PUCK_FRICTION_EN defined, starting at vx=+5: after 40 ticks vx=0; without the macro vx stays +5.
